// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, clock out
// one odd-parity frame on device clock edges, then collect the device ACK.
//
// state       | meaning
// S_IDLE      | lines released, ready for a command byte
// S_INHIBIT   | PS2_CLK held low for INHIBIT_CYCLES
// S_RTS       | PS2_CLK and PS2_DATA low for one cycle (start bit)
// S_SHIFT     | data, parity, stop driven on device falling edges
// S_ACK       | sample device ACK on the next falling edge
// S_WAIT_IDLE | wait for both lines high, then report the result
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] tx_err_code
);
    localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [IW-1:0] INH_LOAD = IW'(INHIBIT_CYCLES - 1);
    localparam logic [20:0]   TO_LAST  = 21'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t        r_state;
    logic          r_clk_meta, r_clk_sync, r_clk_prev;
    logic          r_data_meta, r_data_sync;
    logic [9:0]    r_frame;
    logic [3:0]    r_idx;
    logic [IW-1:0] r_inh_cnt;
    logic [20:0]   r_to_cnt;
    logic          r_nack;
    logic          r_clk_oe, r_data_oe, r_ready, r_busy, r_done, r_err;
    logic [1:0]    r_err_code;

    logic w_clk_fall;
    logic w_timing;
    logic w_timeout;

    // Synchronizers reset to the idle (high) line level so reset never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_clk_prev  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
        end else begin
            r_clk_meta  <= ps2_clk_in;
            r_clk_sync  <= r_clk_meta;
            r_clk_prev  <= r_clk_sync;
            r_data_meta <= ps2_data_in;
            r_data_sync <= r_data_meta;
        end
    end

    assign w_clk_fall = r_clk_prev & ~r_clk_sync;
    assign w_timing   = (r_state == S_SHIFT) || (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
    assign w_timeout  = w_timing && (r_to_cnt >= TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_frame    <= '0;
            r_idx      <= '0;
            r_inh_cnt  <= '0;
            r_to_cnt   <= '0;
            r_nack     <= 1'b0;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_timing && (r_to_cnt != '1)) begin
                r_to_cnt <= r_to_cnt + 21'd1;
            end
            // Timeout takes priority over any edge seen in the same cycle.
            if (w_timeout) begin
                r_state    <= S_IDLE;
                r_clk_oe   <= 1'b0;
                r_data_oe  <= 1'b0;
                r_err_code <= 2'b01;
                r_err      <= 1'b1;
                r_ready    <= 1'b1;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (tx_valid && r_ready) begin
                            r_frame    <= {1'b1, ~^tx_data, tx_data};
                            r_err_code <= 2'b00;
                            r_nack     <= 1'b0;
                            r_inh_cnt  <= INH_LOAD;
                            r_clk_oe   <= 1'b1;
                            r_ready    <= 1'b0;
                            r_busy     <= 1'b1;
                            r_state    <= S_INHIBIT;
                        end
                    end
                    S_INHIBIT: begin
                        if (r_inh_cnt == '0) begin
                            r_data_oe <= 1'b1;
                            r_state   <= S_RTS;
                        end else begin
                            r_inh_cnt <= r_inh_cnt - 1'b1;
                        end
                    end
                    S_RTS: begin
                        r_clk_oe <= 1'b0;
                        r_idx    <= '0;
                        r_to_cnt <= '0;
                        r_state  <= S_SHIFT;
                    end
                    S_SHIFT: begin
                        if (w_clk_fall) begin
                            r_data_oe <= ~r_frame[r_idx];
                            r_idx     <= r_idx + 4'd1;
                            if (r_idx == 4'd9) begin
                                r_state <= S_ACK;
                            end
                        end
                    end
                    S_ACK: begin
                        if (w_clk_fall) begin
                            r_nack <= r_data_sync;
                            if (r_data_sync) begin
                                r_err_code <= 2'b10;
                            end
                            r_state <= S_WAIT_IDLE;
                        end
                    end
                    S_WAIT_IDLE: begin
                        if (r_clk_sync && r_data_sync) begin
                            r_done  <= ~r_nack;
                            r_err   <= r_nack;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_ready    = r_ready;
    assign busy        = r_busy;
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign tx_done     = r_done;
    assign tx_err      = r_err;
    assign tx_err_code = r_err_code;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the
// host on a shared open-drain bus; results are compared with a frame model.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int INH  = 100;
    localparam int TOUT = 5000;
    localparam int HALF = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       busy, tx_done, tx_err;
    logic [1:0] tx_err_code;
    logic       dev_clk_lo = 1'b0;
    logic       dev_data_lo = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    int cyc = 0, last_fall = 0, last_lat = -1;
    int n_done = 0, n_err = 0, run = 0, last_run = 0;
    logic prev_cin = 1'b1, prev_doe = 1'b0;
    logic both_seen = 1'b0, ready_bad = 1'b0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_lo);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_lo);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .tx_err_code(tx_err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: got no finish, expected finish before 1.5 ms");
        $fatal(1);
    end

    // Observer sampled on the inactive edge.
    always @(negedge clk) begin
        cyc      <= cyc + 1;
        prev_cin <= ps2_clk_in;
        prev_doe <= ps2_data_oe;
        if (prev_cin && !ps2_clk_in) last_fall <= cyc;
        if (prev_doe && !ps2_data_oe) last_lat <= cyc - last_fall;
        if (tx_done) n_done <= n_done + 1;
        if (tx_err) n_err <= n_err + 1;
        if (tx_done && tx_err) both_seen <= 1'b1;
        if ((tx_done || tx_err) && !tx_ready) ready_bad <= 1'b1;
        if (ps2_clk_oe) run <= run + 1;
        else if (run != 0) begin
            last_run <= run;
            run      <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    // Frame as seen on the wire: start, LSB-first data, odd parity, stop.
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) if (b[i]) ones++;
        return {1'b1, (ones % 2 == 0), b, 1'b0};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        while (!tx_ready && t < 5000) begin
            tick();
            t++;
        end
        tx_data  = b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check("acc_clk_oe", ps2_clk_oe, 1);
        check("acc_busy", busy, 1);
        check("acc_ready", tx_ready, 0);
    endtask

    // Device: waits for request-to-send, samples mid-high, issues `falls` clocks.
    task automatic dev_rx(input bit nack, input int falls, output logic [10:0] fr, output bit ok);
        int t = 0;
        fr = '0;
        ok = 1'b0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && t < 20000) begin
            tick();
            t++;
        end
        if (t >= 20000) return;
        ok = 1'b1;
        wait_cycles(HALF / 2);
        for (int i = 0; i < falls; i++) begin
            fr[i] = ps2_data_in;
            wait_cycles(HALF / 4);
            if (i == 10 && !nack) dev_data_lo = 1'b1;
            wait_cycles(HALF / 4);
            dev_clk_lo = 1'b1;
            wait_cycles(HALF);
            dev_clk_lo = 1'b0;
            wait_cycles(HALF / 2);
        end
        dev_data_lo = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] b, input bit nack, input string tag);
        logic [10:0] fr;
        bit ok;
        int d0, e0, t;
        d0 = n_done;
        e0 = n_err;
        fork
            send_byte(b);
            dev_rx(nack, 11, fr, ok);
        join
        t = 0;
        while (!tx_ready && t < 2000) begin
            tick();
            t++;
        end
        tick();
        check({tag, "_sync"}, ok, 1);
        check({tag, "_frame"}, fr, exp_frame(b));
        check({tag, "_done"}, n_done - d0, nack ? 0 : 1);
        check({tag, "_err"}, n_err - e0, nack ? 1 : 0);
        check({tag, "_code"}, tx_err_code, nack ? 2'b10 : 2'b00);
        check({tag, "_ready"}, tx_ready, 1);
    endtask

    initial begin
        logic [10:0] fr1, fr2;
        bit ok1, ok2;
        int d0, e0, t;
        logic [7:0] rb;
        bit rn;

        wait_cycles(3);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", tx_ready, 1);
        check("rst_done", tx_done, 0);
        check("rst_err", tx_err, 0);
        check("rst_code", tx_err_code, 0);
        rst_n = 1'b1;
        wait_cycles(5);

        xfer(8'hED, 1'b0, "ed");
        check("ed_clk_oe_len", last_run, INH + 1);
        check("ed_fall_to_doe", last_lat, 3);

        xfer(8'h01, 1'b0, "p01");
        xfer(8'h00, 1'b0, "p00");

        xfer(8'hF4, 1'b1, "nack");

        d0 = n_done;
        e0 = n_err;
        send_byte(8'hA5);
        t = 0;
        while (ps2_clk_oe && t < 1000) begin
            tick();
            t++;
        end
        check("to_rts_exit", ps2_clk_oe, 0);
        wait_cycles(TOUT - 1);
        check("to_pre_doe", ps2_data_oe, 1);
        check("to_pre_err", n_err - e0, 0);
        tick();
        check("to_doe", ps2_data_oe, 0);
        check("to_clk_oe", ps2_clk_oe, 0);
        check("to_err", tx_err, 1);
        check("to_code", tx_err_code, 2'b01);
        check("to_ready", tx_ready, 1);
        tick();
        check("to_err_pulse", tx_err, 0);
        check("to_no_done", n_done - d0, 0);

        d0 = n_done;
        fork
            begin
                int t5;
                send_byte(8'hED);
                tx_data  = 8'hF4;
                tx_valid = 1'b1;
                t5 = 0;
                while (n_done == d0 && t5 < 20000) begin
                    tick();
                    t5++;
                end
                while (!busy && t5 < 20000) begin
                    tick();
                    t5++;
                end
                tx_valid = 1'b0;
            end
            begin
                dev_rx(1'b0, 11, fr1, ok1);
                dev_rx(1'b0, 11, fr2, ok2);
            end
        join
        t = 0;
        while (!tx_ready && t < 2000) begin
            tick();
            t++;
        end
        tick();
        check("hold_sync1", ok1, 1);
        check("hold_sync2", ok2, 1);
        check("hold_frame1", fr1, exp_frame(8'hED));
        check("hold_frame2", fr2, exp_frame(8'hF4));
        check("hold_done", n_done - d0, 2);

        d0 = n_done;
        e0 = n_err;
        fork
            send_byte(8'hED);
            dev_rx(1'b0, 5, fr1, ok1);
        join
        check("rst6_partial", fr1[4:0], exp_frame(8'hED) & 11'h01F);
        check("rst6_bit4_doe", ps2_data_oe, 1);
        check("rst6_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst6_clk_oe", ps2_clk_oe, 0);
        check("rst6_data_oe", ps2_data_oe, 0);
        check("rst6_busy_clr", busy, 0);
        check("rst6_ready", tx_ready, 1);
        check("rst6_code", tx_err_code, 0);
        wait_cycles(4);
        rst_n = 1'b1;
        wait_cycles(4);
        check("rst6_no_done", n_done - d0, 0);
        check("rst6_no_err", n_err - e0, 0);
        xfer(8'hFF, 1'b0, "ff");

        for (int r = 0; r < 3; r++) begin
            rb = 8'($urandom);
            rn = 1'($urandom_range(0, 1));
            xfer(rb, rn, "rnd");
        end

        check("done_err_overlap", both_seen, 0);
        check("pulse_ready", ready_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
